// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and constants for the inference datapath
package nn_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    FINISH
  } sched_state_t;

  typedef logic signed [DATA_W-1:0] data_t;

endpackage

// File: rtl/argmax_tracker.sv
// rtl/argmax_tracker.sv - pass-local running maximum and its index
module argmax_tracker #(
  parameter int IDX_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic                     update,
  input  logic [IDX_W-1:0]         in_idx,
  input  logic signed [DATA_W-1:0] in_val,
  output logic [IDX_W-1:0]         max_idx,
  output logic signed [DATA_W-1:0] max_val
);

  logic [IDX_W-1:0]         max_idx_q, max_idx_d;
  logic signed [DATA_W-1:0] max_val_q, max_val_d;

  // First entry always loads; later ones replace only when strictly greater so ties keep the lower index
  always_comb begin
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;
    if (clear) begin
      max_idx_d = '0;
      max_val_d = '0;
    end else if (load || (update && (in_val > max_val_q))) begin
      max_idx_d = in_idx;
      max_val_d = in_val;
    end
  end

  // Tracker registers
  always_ff @(posedge clk) begin
    if (rst) begin
      max_idx_q <= '0;
      max_val_q <= '0;
    end else begin
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
    end
  end

  assign max_idx = max_idx_q;
  assign max_val = max_val_q;

endmodule

// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - sequences one shared neuron across all outputs of a layer
module layer_scheduler #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_W      = nn_pkg::DATA_W,
  parameter int TIMEOUT     = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             layer_start,
  input  logic                             layer_abort,
  output logic                             busy,
  output logic                             layer_done,
  output logic                             error,
  output logic [$clog2(NUM_NEURONS)-1:0]   neuron_idx,
  output logic                             neuron_start,
  input  logic                             neuron_done,
  input  logic signed [DATA_W-1:0]         neuron_result,
  input  logic [$clog2(NUM_NEURONS)-1:0]   rd_addr,
  output logic signed [DATA_W-1:0]         rd_data,
  output logic [$clog2(NUM_NEURONS)-1:0]   argmax_idx,
  output logic signed [DATA_W-1:0]         argmax_val
);

  import nn_pkg::*;

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam int CNT_W = $clog2(TIMEOUT);
  // Buffer rounded up to a power of two so any rd_addr reads a defined (zero) entry
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  sched_state_t             state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     error_q, error_d;
  logic                     done_q, done_d;
  logic [IDX_W-1:0]         argmax_idx_q, argmax_idx_d;
  logic signed [DATA_W-1:0] argmax_val_q, argmax_val_d;
  logic signed [DATA_W-1:0] buf_q [DEPTH];
  logic signed [DATA_W-1:0] buf_d [DEPTH];

  logic                     trk_clear, trk_load, trk_update;
  logic [IDX_W-1:0]         trk_idx;
  logic signed [DATA_W-1:0] trk_val;

  argmax_tracker #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_argmax (
    .clk     (clk),
    .rst     (rst),
    .clear   (trk_clear),
    .load    (trk_load),
    .update  (trk_update),
    .in_idx  (idx_q),
    .in_val  (neuron_result),
    .max_idx (trk_idx),
    .max_val (trk_val)
  );

  // Next-state and datapath control; abort preempts every other transition out of a busy state
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    error_d      = error_q;
    done_d       = 1'b0;
    argmax_idx_d = argmax_idx_q;
    argmax_val_d = argmax_val_q;
    buf_d        = buf_q;
    trk_clear    = 1'b0;
    trk_load     = 1'b0;
    trk_update   = 1'b0;
    neuron_start = 1'b0;
    if ((state_q != IDLE) && layer_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (layer_start) begin
            state_d   = ISSUE;
            idx_d     = '0;
            cnt_d     = '0;
            error_d   = 1'b0;
            trk_clear = 1'b1;
          end
        end
        ISSUE: begin
          neuron_start = 1'b1;
          state_d      = WAIT;
        end
        WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (neuron_done) begin
            state_d = CAPTURE;
          end else if (cnt_d == CNT_LIMIT) begin
            state_d = IDLE;
            error_d = 1'b1;
          end
        end
        CAPTURE: begin
          buf_d[idx_q] = neuron_result;
          trk_load     = (idx_q == '0);
          trk_update   = (idx_q != '0);
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = '0;
            state_d = ISSUE;
          end
        end
        FINISH: begin
          argmax_idx_d = trk_idx;
          argmax_val_d = trk_val;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters, result buffer and published argmax
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      argmax_idx_q <= '0;
      argmax_val_q <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      error_q      <= error_d;
      done_q       <= done_d;
      argmax_idx_q <= argmax_idx_d;
      argmax_val_q <= argmax_val_d;
      buf_q        <= buf_d;
    end
  end

  // layer_done is registered out of FINISH, so busy is already low while it pulses
  assign busy       = (state_q != IDLE);
  assign layer_done = done_q;
  assign error      = error_q;
  assign neuron_idx = idx_q;
  assign rd_data    = buf_q[rd_addr];
  assign argmax_idx = argmax_idx_q;
  assign argmax_val = argmax_val_q;

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
Sequences one shared MAC neuron unit across all NUM_NEURONS outputs of a fully-connected layer. For each output it issues a start pulse and drives the neuron/bias index to the weight-memory mux. It waits for the neuron's done pulse, captures the ReLU'd result into an internal result buffer, and tracks the running argmax. It sits between the top-level inference FSM (layer_start/layer_done) and one neuron instance plus its weight/bias ROMs.

Parameters:
NUM_NEURONS, 10, outputs in this layer (≥2)
DATA_W, 16, signed result width
TIMEOUT, 1024, max cycles waiting for neuron_done before error (must exceed neuron latency, INPUT_SIZE+2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
layer_start  in  1  begin a layer pass; sampled only in IDLE
layer_abort  in  1  cancel pass; return to IDLE, no layer_done
busy  out  1  high from the cycle after accepted start until return to IDLE
layer_done  out  1  one-cycle pulse after last result captured
error  out  1  sticky timeout flag; cleared by the next accepted layer_start or rst
neuron_idx  out  $clog2(NUM_NEURONS)  selects weight row and bias for the neuron
neuron_start  out  1  one-cycle start pulse to neuron
neuron_done  in  1  neuron's one-cycle done pulse
neuron_result  in  DATA_W signed  neuron output; valid the cycle AFTER neuron_done
rd_addr  in  $clog2(NUM_NEURONS)  result buffer read address
rd_data  out  DATA_W signed  combinational read of buffer[rd_addr]
argmax_idx  out  $clog2(NUM_NEURONS)  index of largest result of last completed pass
argmax_val  out  DATA_W signed  value at argmax_idx

Behaviour:
- Reset: all outputs 0, buffer cleared to 0, state IDLE, counters 0.
- States: IDLE, ISSUE, WAIT, CAPTURE, FINISH.
- IDLE: if layer_start, go to ISSUE. Set neuron_idx=0, clear error, reset the wait counter. busy=1 from the next cycle.
- ISSUE: assert neuron_start for exactly one cycle. neuron_idx is stable from ISSUE through CAPTURE. Go to WAIT.
- WAIT: increment the wait counter each cycle.
  - neuron_done=1: go to CAPTURE.
  - Counter reaches TIMEOUT-1 without done: set error=1 and go to IDLE. No layer_done; buffer and argmax keep their prior values.
- CAPTURE (the cycle after done):
  - Write neuron_result to buffer[neuron_idx].
  - Update the pass-local max: the first neuron always loads; later neurons replace only if strictly greater, so ties keep the lower index.
  - If neuron_idx==NUM_NEURONS-1, go to FINISH. Otherwise increment neuron_idx, clear the counter, and go to ISSUE.
- FINISH: copy the pass-local max to argmax_idx/argmax_val, pulse layer_done, go to IDLE. busy drops the same cycle layer_done is high.
- Per-neuron overhead: 3 cycles (ISSUE, done-wait exit, CAPTURE) plus neuron latency. One FINISH cycle per pass.
- layer_start while not IDLE is ignored.
- layer_abort in any non-IDLE state: go to IDLE next cycle.
  - Any pending neuron_start is suppressed.
  - Buffer entries already written stay; argmax outputs are unchanged.
  - Abort has priority over done, timeout and FINISH in the same cycle.
- neuron_done in any state other than WAIT is ignored.
- rst mid-pass: immediate return to the reset state on the next edge, regardless of state.
- Buffer reads are combinational and may observe partial results during a pass.

Decomposition:
- Shared package nn_pkg holds:
  - DATA_W default constant
  - sched_state_t enum (IDLE, ISSUE, WAIT, CAPTURE, FINISH)
  - a signed data typedef
- One natural sub-module: argmax_tracker. It holds the pass-local running max and index, with clear/load/update and strict-greater compare. The top FSM drives it.

Test Plan:
- NUM_NEURONS=4, stub neuron with latency 5 returning {3,9,9,1} → four single-cycle neuron_start pulses with neuron_idx 0..3; layer_done exactly once; buffer={3,9,9,1}; argmax_idx=1, argmax_val=9 (tie keeps lower index).
- layer_start re-asserted every cycle during a pass → still one pulse per neuron; no second pass begins until after layer_done.
- Stub never asserts done, TIMEOUT=16 → error=1 16 cycles after start; state returns to IDLE, busy=0, no layer_done. A following layer_start clears error.
- layer_abort in the same cycle as neuron_done for neuron 2 → IDLE next cycle; buffer[2] not written; no layer_done; argmax unchanged from the prior pass.
- rst asserted during WAIT of neuron 1 → next cycle all outputs 0, buffer all 0, neuron_start stays 0.
- Results all 0 (ReLU-clamped) → argmax_idx=0, argmax_val=0; a spurious neuron_done in IDLE causes no buffer write.
